// File: rtl/int2float.sv
// int2float: registered 11-bit unsigned integer to 7-bit mini-float compressor.
// The output is a 3-bit exponent and a 4-bit mantissa that carries its own
// leading one (there is no hidden bit). The value decodes as M << E.
// Bits below the mantissa are truncated toward zero.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears E and M and takes priority
//   B    11-bit unsigned operand (B[10] is the MSB), not registered here
//   E    registered exponent, 0..7
//   M    registered mantissa, 0..15 (8..15 whenever E > 0)
module int2float (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] B,
  output logic [2:0]  E,
  output logic [3:0]  M
);

  localparam int unsigned EXP_W = 3;
  localparam int unsigned MAN_W = 4;

  logic [EXP_W-1:0] e_c;
  logic [MAN_W-1:0] m_c;

  // Leading-one priority encoder over B[10:4]; the exponent is p - 3, or 0 if B < 16.
  always_comb begin
    e_c = '0;
    casez (B[10:4])
      7'b1??????: e_c = EXP_W'(7);
      7'b01?????: e_c = EXP_W'(6);
      7'b001????: e_c = EXP_W'(5);
      7'b0001???: e_c = EXP_W'(4);
      7'b00001??: e_c = EXP_W'(3);
      7'b000001?: e_c = EXP_W'(2);
      7'b0000001: e_c = EXP_W'(1);
      default:    e_c = '0;
    endcase
  end

  // Mantissa mux: the 4-bit window that starts at the leading one (B >> E).
  always_comb begin
    m_c = B[3:0];
    case (e_c)
      3'd1:    m_c = B[4:1];
      3'd2:    m_c = B[5:2];
      3'd3:    m_c = B[6:3];
      3'd4:    m_c = B[7:4];
      3'd5:    m_c = B[8:5];
      3'd6:    m_c = B[9:6];
      3'd7:    m_c = B[10:7];
      default: m_c = B[3:0];
    endcase
  end

  // Output register; reset wins over the conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      E <= '0;
      M <= '0;
    end else begin
      E <= e_c;
      M <= m_c;
    end
  end

endmodule

// File: tb/tb_int2float.sv
// Directed and exhaustive self-checking bench for int2float.
module tb_int2float;

  logic        clk;
  logic        rst;
  logic [10:0] B;
  logic [2:0]  E;
  logic [3:0]  M;

  int n_checks;
  int n_fail;

  int2float dut (
    .clk (clk),
    .rst (rst),
    .B   (B),
    .E   (E),
    .M   (M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference exponent: position of the leading one found by a bit scan.
  function automatic int ref_e(input logic [10:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 11; i++)
      if (b[i]) p = i;
    return (p > 3) ? p - 3 : 0;
  endfunction

  function automatic int ref_m(input logic [10:0] b);
    return int'(b) / (1 << ref_e(b));
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    B   = 11'h7FF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (E !== 3'd0 || M !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got E=%0d M=%0d, want E=0 M=0", k, E, M);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (E !== 3'd7 || M !== 4'd15) begin
      n_fail++;
      $display("FAIL reset_release: got E=%0d M=%0d, want E=7 M=15", E, M);
    end
  endtask

  task automatic test_small_range;
    logic [10:0] vb [3] = '{11'd0, 11'd1, 11'd15};
    logic [3:0]  vm [3] = '{4'd0, 4'd1, 4'd15};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      B = vb[k];
      @(posedge clk); #1;
      n_checks++;
      if (E !== 3'd0 || M !== vm[k]) begin
        n_fail++;
        $display("FAIL small_range B=%0d: got E=%0d M=%0d, want E=0 M=%0d", vb[k], E, M, vm[k]);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [10:0] vb [5] = '{11'd16, 11'd31, 11'd32, 11'h400, 11'h7FF};
    logic [2:0]  ve [5] = '{3'd1, 3'd1, 3'd2, 3'd7, 3'd7};
    logic [3:0]  vm [5] = '{4'd8, 4'd15, 4'd8, 4'd8, 4'd15};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      B = vb[k];
      @(posedge clk); #1;
      n_checks++;
      if (E !== ve[k] || M !== vm[k]) begin
        n_fail++;
        $display("FAIL boundary B=0x%0h: got E=%0d M=%0d, want E=%0d M=%0d", vb[k], E, M, ve[k], vm[k]);
      end
    end
  endtask

  task automatic test_patterns;
    logic [10:0] vb [4] = '{11'h555, 11'h2AA, 11'h0FF, 11'h011};
    logic [2:0]  ve [4] = '{3'd7, 3'd6, 3'd4, 3'd1};
    logic [3:0]  vm [4] = '{4'd10, 4'd10, 4'd15, 4'd8};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      B = vb[k];
      @(posedge clk); #1;
      n_checks++;
      if (E !== ve[k] || M !== vm[k]) begin
        n_fail++;
        $display("FAIL pattern B=0x%0h: got E=%0d M=%0d, want E=%0d M=%0d", vb[k], E, M, ve[k], vm[k]);
      end
    end
  endtask

  // Full sweep, one value per cycle, with a one-cycle reset dropped in mid-stream.
  task automatic test_exhaustive;
    int lo, hi;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      B   = 11'(i);
      rst = (i == 1000);
      @(posedge clk); #1;
      n_checks++;
      if (i == 1000) begin
        if (E !== 3'd0 || M !== 4'd0) begin
          n_fail++;
          $display("FAIL sweep_reset B=%0d: got E=%0d M=%0d, want E=0 M=0", i, E, M);
        end
      end else begin
        if (E !== 3'(ref_e(11'(i))) || M !== 4'(ref_m(11'(i)))) begin
          n_fail++;
          $display("FAIL sweep B=%0d: got E=%0d M=%0d, want E=%0d M=%0d",
                   i, E, M, ref_e(11'(i)), ref_m(11'(i)));
        end
        lo = int'(M) << E;
        hi = (int'(M) + 1) << E;
        n_checks++;
        if (!(lo <= i && i < hi)) begin
          n_fail++;
          $display("FAIL sweep_bounds B=%0d: got range [%0d,%0d), want B inside", i, lo, hi);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_static_hold;
    logic [10:0] vb [3] = '{11'h000, 11'h7FF, 11'h555};
    logic [2:0]  ve [3] = '{3'd0, 3'd7, 3'd7};
    logic [3:0]  vm [3] = '{4'd0, 4'd15, 4'd10};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      B = vb[k];
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        n_checks++;
        if (E !== ve[k] || M !== vm[k]) begin
          n_fail++;
          $display("FAIL static_hold B=0x%0h cycle %0d: got E=%0d M=%0d, want E=%0d M=%0d",
                   vb[k], c, E, M, ve[k], vm[k]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    B        = '0;
    test_reset();
    test_small_range();
    test_boundaries();
    test_patterns();
    test_exhaustive();
    test_static_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
